traffic_light_ctrl: RTL and testbench

Parametrised N-phase, demand-actuated traffic light controller. It generalises the fixed two-direction (NS/EW) controller to NUM_PHASES phases with programmable green/yellow/all-red timing. It adds latched demand requests and green extension: green is held while no other phase has demand, up to a maximum. It is a standalone top-level leaf driving per-phase lamp outputs.

---
 rtl/traffic_light_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   N-phase demand-actuated traffic light controller with latched requests,
//   minimum/maximum green with extension, yellow and all-red clearance.
//   Optional flashing-yellow mode is compiled in with `define TL_FLASH_EN.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req_i     per-phase demand (pulse or level)
//   green_o   per-phase green lamp (registered)
//   yellow_o  per-phase yellow lamp (registered)
//   red_o     per-phase red lamp (registered)
//   phase_o   index of the current / last served phase
//   pend_o    latched pending-demand vector
//   flash_i   flash-mode request (only with TL_FLASH_EN)
module traffic_light_ctrl #(
  parameter int unsigned NUM_PHASES = 2,
  parameter int unsigned GREEN_MIN  = 8,
  parameter int unsigned GREEN_MAX  = 32,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned FLASH_CYC  = 4,
  localparam int unsigned PH_W      = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PHASES-1:0] req_i,
  output logic [NUM_PHASES-1:0] green_o,
  output logic [NUM_PHASES-1:0] yellow_o,
  output logic [NUM_PHASES-1:0] red_o,
  output logic [PH_W-1:0]       phase_o,
  output logic [NUM_PHASES-1:0] pend_o
`ifdef TL_FLASH_EN
  ,
  input  logic                  flash_i
`endif
);

  localparam int unsigned MAX_GY  = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
  localparam int unsigned MAX_AF  = (ALLRED_CYC > FLASH_CYC) ? ALLRED_CYC : FLASH_CYC;
  localparam int unsigned MAX_DUR = (MAX_GY > MAX_AF) ? MAX_GY : MAX_AF;
  localparam int unsigned TW      = $clog2(MAX_DUR) + 1;

  localparam logic [TW-1:0] GMIN_M1 = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_M1 = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] AR_M1   = TW'(ALLRED_CYC - 1);
`ifdef TL_FLASH_EN
  localparam logic [TW-1:0] FL_M1   = TW'(FLASH_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW
`ifdef TL_FLASH_EN
    ,
    S_FLASH
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [TW-1:0]           gcnt_q, gcnt_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [NUM_PHASES-1:0]   pend_q, pend_d;
  logic [NUM_PHASES-1:0]   green_q, green_d;
  logic [NUM_PHASES-1:0]   yellow_q, yellow_d;
  logic [NUM_PHASES-1:0]   red_q, red_d;
`ifdef TL_FLASH_EN
  logic                    flash_on_q, flash_on_d;
`endif

  logic [NUM_PHASES-1:0]   cur_oh, nxt_oh, own, dem;
  logic [PH_W-1:0]         nxt_phase;
  int unsigned             idx;

  always_comb begin
    cur_oh          = '0;
    cur_oh[phase_q] = 1'b1;
    dem             = pend_q | req_i;

    // Round-robin search: scanning from the farthest offset down to the
    // nearest lets the closest demanding phase overwrite earlier hits.
    nxt_phase = PH_W'((32'(phase_q) + 32'd1) % NUM_PHASES);
    idx       = 0;
    for (int unsigned k = NUM_PHASES; k >= 1; k--) begin
      idx = (32'(phase_q) + k) % NUM_PHASES;
      if (dem[PH_W'(idx)]) nxt_phase = PH_W'(idx);
    end

    state_d = state_q;
    timer_d = timer_q;
    gcnt_d  = gcnt_q;
    phase_d = phase_q;
`ifdef TL_FLASH_EN
    flash_on_d = flash_on_q;
`endif

    // Requests for the phase currently being served are not latched.
    own    = (state_q == S_GREEN || state_q == S_YELLOW) ? cur_oh : '0;
    pend_d = pend_q | (req_i & ~own);

    case (state_q)
      S_ALL_RED: begin
        if (timer_q == '0) begin
          state_d = S_GREEN;
          gcnt_d  = '0;
          phase_d = nxt_phase;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_GREEN: begin
        if ((gcnt_q >= GMIN_M1 && |(dem & ~cur_oh)) || gcnt_q == GMAX_M1) begin
          state_d = S_YELLOW;
          timer_d = YEL_M1;
        end else begin
          gcnt_d = gcnt_q + TW'(1);
        end
      end
      S_YELLOW: begin
        if (timer_q == '0) begin
          state_d = S_ALL_RED;
          timer_d = AR_M1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef TL_FLASH_EN
      S_FLASH: begin
        if (!flash_i) begin
          state_d = S_ALL_RED;
          timer_d = AR_M1;
        end else if (timer_q == '0) begin
          flash_on_d = ~flash_on_q;
          timer_d    = FL_M1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`endif
      default: begin
        state_d = S_ALL_RED;
        timer_d = AR_M1;
      end
    endcase

`ifdef TL_FLASH_EN
    // Flash entry overrides any normal transition, including a green start.
    if (flash_i && state_q != S_FLASH) begin
      state_d    = S_FLASH;
      timer_d    = FL_M1;
      phase_d    = phase_q;
      flash_on_d = 1'b1;
    end
`endif

    // Clearing is applied after the flash override so a suppressed green
    // start leaves the pending bit intact.
    if (state_d == S_GREEN && state_q != S_GREEN) pend_d[phase_d] = 1'b0;

    nxt_oh          = '0;
    nxt_oh[phase_d] = 1'b1;
    green_d  = (state_d == S_GREEN)  ? nxt_oh : '0;
    yellow_d = (state_d == S_YELLOW) ? nxt_oh : '0;
    red_d    = ~(green_d | yellow_d);
`ifdef TL_FLASH_EN
    if (state_d == S_FLASH) begin
      yellow_d = {NUM_PHASES{flash_on_d}};
      red_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ALL_RED;
      timer_q  <= AR_M1;
      gcnt_q   <= '0;
      phase_q  <= PH_W'(NUM_PHASES - 1);
      pend_q   <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
`ifdef TL_FLASH_EN
      flash_on_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      gcnt_q   <= gcnt_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
`ifdef TL_FLASH_EN
      flash_on_q <= flash_on_d;
`endif
    end
  end

  assign green_o  = green_q;
  assign yellow_o = yellow_q;
  assign red_o    = red_q;
  assign phase_o  = phase_q;
  assign pend_o   = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a 2-phase instance driven from a vector
// table plus hand sequences, and a 4-phase instance checked against a
// behavioural model. Expected records go through a queue scoreboard.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] req2;
  logic [3:0] req4;
  logic       flash2, flash4;
  logic [1:0] g2, y2, r2, pend2;
  logic [0:0] ph2;
  logic [3:0] g4, y4, r4, pend4;
  logic [1:0] ph4;

  traffic_light_ctrl u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req2),
    .green_o  (g2),
    .yellow_o (y2),
    .red_o    (r2),
    .phase_o  (ph2),
    .pend_o   (pend2)
`ifdef TL_FLASH_EN
    ,
    .flash_i  (flash2)
`endif
  );

  traffic_light_ctrl #(.NUM_PHASES(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req4),
    .green_o  (g4),
    .yellow_o (y4),
    .red_o    (r4),
    .phase_o  (ph4),
    .pend_o   (pend4)
`ifdef TL_FLASH_EN
    ,
    .flash_i  (flash4)
`endif
  );

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic [1:0] ph;
    logic [3:0] pend;
  } exp_t;

  typedef struct {
    logic [1:0] req;
    int         n;
    logic [1:0] g, y, r;
    logic       ph;
    logic [1:0] pend;
  } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk2(logic [1:0] g, logic [1:0] y, logic [1:0] r,
                               logic ph, logic [1:0] pend);
    exp_t e;
    e.g = {2'b00, g}; e.y = {2'b00, y}; e.r = {2'b00, r};
    e.ph = {1'b0, ph}; e.pend = {2'b00, pend};
    return e;
  endfunction

  function automatic exp_t act2();
    return mk2(g2, y2, r2, ph2[0], pend2);
  endfunction

  function automatic exp_t act4();
    exp_t e;
    e.g = g4; e.y = y4; e.r = r4; e.ph = ph4; e.pend = pend4;
    return e;
  endfunction

  function automatic void add(logic [1:0] req, int n, logic [1:0] g, logic [1:0] y,
                              logic [1:0] r, logic ph, logic [1:0] pend);
    vec_t v;
    v.req = req; v.n = n; v.g = g; v.y = y; v.r = r; v.ph = ph; v.pend = pend;
    tbl.push_back(v);
  endfunction

  task automatic check_pop(input string name, input exp_t a);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got g=%b y=%b r=%b", name, a.g, a.y, a.r);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got g=%b y=%b r=%b ph=%0d pend=%b, expected g=%b y=%b r=%b ph=%0d pend=%b",
                 name, a.g, a.y, a.r, a.ph, a.pend, e.g, e.y, e.r, e.ph, e.pend);
      end
    end
  endtask

  task automatic step2(input logic [1:0] req, input exp_t e, input string name);
    req2 = req;
    q.push_back(e);
    @(posedge clk);
    #1;
    check_pop(name, act2());
  endtask

  // Behavioural model of the 4-phase instance, counting cycles spent in
  // each state rather than loading down-timers.
  int         m_st;   // 0 all-red, 1 green, 2 yellow
  int         m_age;
  int         m_ph;
  logic [3:0] m_pend;

  function automatic void model_reset();
    m_st = 0; m_age = 0; m_ph = 3; m_pend = 4'b0000;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [3:0] oh;
    oh = 4'b0001 << m_ph;
    e.g = (m_st == 1) ? oh : 4'b0000;
    e.y = (m_st == 2) ? oh : 4'b0000;
    e.r = ~(e.g | e.y);
    e.ph = 2'(m_ph);
    e.pend = m_pend;
    return e;
  endfunction

  function automatic void model_step(logic [3:0] req);
    logic [3:0] dem, own, np;
    int nst, nage, nph, p;
    bit found;
    dem = m_pend | req;
    own = (m_st == 1 || m_st == 2) ? (4'b0001 << m_ph) : 4'b0000;
    np = m_pend | (req & ~own);
    nst = m_st; nage = m_age + 1; nph = m_ph;
    if (m_st == 0) begin
      if (m_age + 1 == 2) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          p = (m_ph + k) % 4;
          if (!found && dem[p]) begin nph = p; found = 1'b1; end
        end
        if (!found) nph = (m_ph + 1) % 4;
        nst = 1; nage = 0; np[nph] = 1'b0;
      end
    end else if (m_st == 1) begin
      if ((m_age + 1 >= 8 && (dem & ~(4'b0001 << m_ph)) != 4'b0000) || m_age + 1 == 32) begin
        nst = 2; nage = 0;
      end
    end else begin
      if (m_age + 1 == 3) begin nst = 0; nage = 0; end
    end
    m_st = nst; m_age = nage; m_ph = nph; m_pend = np;
  endfunction

  initial begin
    int         greens[$];
    logic [3:0] prev_g;
    logic [3:0] nonred;
    bit         bad;

    rst_n = 1'b0; req2 = 2'b00; req4 = 4'b0000; flash2 = 1'b0; flash4 = 1'b0;

    // 2-phase timeline after reset release (req, cycles, g, y, r, phase, pend)
    add(2'b00,  1, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00);
    add(2'b00, 32, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00);
    add(2'b00,  3, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00);
    add(2'b00, 32, 2'b10, 2'b00, 2'b01, 1'b1, 2'b00);
    add(2'b00,  3, 2'b00, 2'b10, 2'b01, 1'b1, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00);
    add(2'b00,  1, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00);
    // req_i[1] held: minimum green for phase 0, phase 1 then runs to maximum
    add(2'b10,  7, 2'b01, 2'b00, 2'b10, 1'b0, 2'b10);
    add(2'b10,  3, 2'b00, 2'b01, 2'b10, 1'b0, 2'b10);
    add(2'b10,  2, 2'b00, 2'b00, 2'b11, 1'b0, 2'b10);
    add(2'b10, 32, 2'b10, 2'b00, 2'b01, 1'b1, 2'b00);
    add(2'b00,  3, 2'b00, 2'b10, 2'b01, 1'b1, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00);
    add(2'b00,  1, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00);
    // single pulse on req_i[1] at green cycle 20 of phase 0
    add(2'b00, 20, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00);
    add(2'b10,  1, 2'b00, 2'b01, 2'b10, 1'b0, 2'b10);
    add(2'b00,  2, 2'b00, 2'b01, 2'b10, 1'b0, 2'b10);
    add(2'b00,  2, 2'b00, 2'b00, 2'b11, 1'b0, 2'b10);
    add(2'b00,  1, 2'b10, 2'b00, 2'b01, 1'b1, 2'b00);
    add(2'b00, 31, 2'b10, 2'b00, 2'b01, 1'b1, 2'b00);
    add(2'b00,  3, 2'b00, 2'b10, 2'b01, 1'b1, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00);
    add(2'b00,  1, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00);

    repeat (2) @(posedge clk);
    #1;
    q.push_back(mk2(2'b00, 2'b00, 2'b11, 1'b1, 2'b00));
    check_pop("reset2", act2());
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      for (int j = 0; j < tbl[i].n; j++)
        step2(tbl[i].req, mk2(tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].ph, tbl[i].pend),
              $sformatf("tbl%0d_c%0d", i, j));

    // Reset asserted in the middle of a yellow interval
    step2(2'b10, mk2(2'b01, 2'b00, 2'b10, 1'b0, 2'b10), "rst_seq_g1");
    for (int j = 0; j < 6; j++)
      step2(2'b00, mk2(2'b01, 2'b00, 2'b10, 1'b0, 2'b10), "rst_seq_g");
    step2(2'b00, mk2(2'b00, 2'b01, 2'b10, 1'b0, 2'b10), "rst_seq_y");
    #2;
    rst_n = 1'b0;
    #1;
    q.push_back(mk2(2'b00, 2'b00, 2'b11, 1'b1, 2'b00));
    check_pop("async_reset", act2());
    @(posedge clk);
    #1;
    q.push_back(mk2(2'b00, 2'b00, 2'b11, 1'b1, 2'b00));
    check_pop("reset_hold", act2());
    rst_n = 1'b1;
    step2(2'b00, mk2(2'b00, 2'b00, 2'b11, 1'b1, 2'b00), "restart_red");
    step2(2'b00, mk2(2'b01, 2'b00, 2'b10, 1'b0, 2'b00), "restart_g0");

`ifdef TL_FLASH_EN
    flash2 = 1'b1;
    for (int i = 0; i < 20; i++)
      step2(2'b00, mk2(2'b00, ((i / 4) % 2 == 0) ? 2'b11 : 2'b00, 2'b00, 1'b0, 2'b00),
            $sformatf("flash_c%0d", i));
    flash2 = 1'b0;
    step2(2'b00, mk2(2'b00, 2'b00, 2'b11, 1'b0, 2'b00), "flash_exit_r0");
    step2(2'b00, mk2(2'b00, 2'b00, 2'b11, 1'b0, 2'b00), "flash_exit_r1");
    step2(2'b00, mk2(2'b10, 2'b00, 2'b01, 1'b1, 2'b00), "flash_exit_g1");
`endif

    // 4-phase instance against the model
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    q.push_back(model_out());
    check_pop("reset4", act4());
    rst_n = 1'b1;
    prev_g = 4'b0000;
    for (int c = 1; c <= 400; c++) begin
      if (c == 10)      req4 = 4'b1000;
      else if (c == 14) req4 = 4'b0100;
      else if (c > 60 && $urandom_range(0, 7) == 0)
        req4 = 4'b0001 << $urandom_range(0, 3);
      else              req4 = 4'b0000;
      model_step(req4);
      q.push_back(model_out());
      @(posedge clk);
      #1;
      check_pop($sformatf("p4_c%0d", c), act4());
      nonred = ~r4;
      bad = ($countones(nonred) > 1);
      for (int p = 0; p < 4; p++)
        if ((32'(g4[p]) + 32'(y4[p]) + 32'(r4[p])) != 1) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL p4_lamps_c%0d: got g=%b y=%b r=%b, required one lamp per phase and at most one non-red phase",
                 c, g4, y4, r4);
      end
      if (g4 != 4'b0000 && prev_g == 4'b0000) greens.push_back(int'(ph4));
      prev_g = g4;
    end
    req4 = 4'b0000;

    checks++;
    if (greens.size() < 3) begin
      errors++;
      $display("FAIL p4_order: got %0d green starts, required at least 3", greens.size());
    end else if (greens[0] != 0 || greens[1] != 2 || greens[2] != 3) begin
      errors++;
      $display("FAIL p4_order: got %0d,%0d,%0d, required 0,2,3", greens[0], greens[1], greens[2]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
